// File: rtl/cpu_step_sequencer_if.sv
// Control bundle between the step sequencer and the CPU datapath.
// The master side is the sequencer; the slave side is the datapath (or a bench).
interface cpu_step_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [15:0]      ins_word;
    logic             pc_inc;
    logic             pc_load;
    logic             ins_load;
    logic             ext_load;
    logic             ram_rd;
    logic             op1_load;
    logic             op2_load;
    logic [1:0]       alu_ot;
    logic             reg_load;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  en, ins_word,
        output pc_inc, pc_load, ins_load, ext_load, ram_rd, op1_load, op2_load,
               alu_ot, reg_load, busy, halted, illegal, retired
    );

    modport slave (
        output en, ins_word,
        input  pc_inc, pc_load, ins_load, ext_load, ram_rd, op1_load, op2_load,
               alu_ot, reg_load, busy, halted, illegal, retired
    );
endinterface

// File: rtl/cpu_step_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU datapath.
// Outputs are a registered decode of the state being entered, so they are Moore.
module cpu_step_sequencer #(
    parameter int ROM_LAT = 1,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    cpu_step_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_MEMRD,
        S_OPRD, S_EXEC, S_WB, S_HALT, S_TRAP
    } state_t;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_load;
        logic       ins_load;
        logic       ext_load;
        logic       ram_rd;
        logic       op1_load;
        logic       op2_load;
        logic [1:0] alu_ot;
        logic       reg_load;
        logic       busy;
        logic       halted;
        logic       illegal;
    } outs_t;

    localparam logic [2:0] ROM_LAST = 3'(ROM_LAT - 1);
    localparam logic [2:0] RAM_LAST = 3'(RAM_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       wait_q, wait_d;
    // Only the fields the controller decodes are kept; operand selects go to the splitter.
    logic [1:0]       byte_q, mode_q, ot_q;
    logic [3:0]       opc_q;
    logic [CNT_W-1:0] retired_q;
    outs_t            outs_q;
    logic             unused_fields;

    assign unused_fields = ^bus.ins_word[9:4];

    function automatic outs_t decode_outs(input state_t s, input logic [2:0] w,
                                          input logic [1:0] ot);
        outs_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.busy     = 1'b1;
                o.ins_load = (w == ROM_LAST);
                o.pc_inc   = (w == ROM_LAST);
            end
            S_FETCH2: begin
                o.busy     = 1'b1;
                o.ext_load = (w == ROM_LAST);
                o.pc_inc   = (w == ROM_LAST);
            end
            S_DECODE: o.busy = 1'b1;
            S_MEMRD: begin
                o.busy   = 1'b1;
                o.ram_rd = 1'b1;
            end
            S_OPRD: begin
                o.busy     = 1'b1;
                o.op1_load = 1'b1;
                o.op2_load = 1'b1;
            end
            S_EXEC: begin
                o.busy   = 1'b1;
                o.alu_ot = ot;
            end
            S_WB: begin
                o.busy     = 1'b1;
                o.reg_load = 1'b1;
            end
            S_HALT:  o.halted  = 1'b1;
            S_TRAP:  o.illegal = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default up front so no path can infer a latch.
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_IDLE: if (bus.en) state_d = S_FETCH;
            S_FETCH: begin
                if (wait_q == ROM_LAST) state_d = S_DECODE;
                else                    wait_d  = wait_q + 3'd1;
            end
            S_DECODE: begin
                if (!(byte_q inside {2'b01, 2'b10}) || mode_q == 2'b11 || ot_q == 2'b11)
                    state_d = S_TRAP;
                else if (ot_q == 2'b00 && opc_q == 4'hF)
                    state_d = S_HALT;
                else if (byte_q == 2'b10)
                    state_d = S_FETCH2;
                else if (mode_q != 2'b00)
                    state_d = S_TRAP;
                else
                    state_d = S_OPRD;
            end
            S_FETCH2: begin
                if (wait_q == ROM_LAST) state_d = (mode_q == 2'b10) ? S_MEMRD : S_OPRD;
                else                    wait_d  = wait_q + 3'd1;
            end
            S_MEMRD: begin
                if (wait_q == RAM_LAST) state_d = S_OPRD;
                else                    wait_d  = wait_q + 3'd1;
            end
            S_OPRD:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            // en is only honoured here, so a running instruction always completes.
            S_WB:    state_d = bus.en ? S_FETCH : S_IDLE;
            S_HALT,
            S_TRAP:  state_d = state_q;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            byte_q    <= '0;
            mode_q    <= '0;
            ot_q      <= '0;
            opc_q     <= '0;
            retired_q <= '0;
            outs_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            outs_q  <= decode_outs(state_d, wait_d, ot_q);
            if (state_q == S_FETCH && wait_q == ROM_LAST) begin
                byte_q <= bus.ins_word[15:14];
                mode_q <= bus.ins_word[13:12];
                ot_q   <= bus.ins_word[11:10];
                opc_q  <= bus.ins_word[3:0];
            end
            if (state_q == S_WB) retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.pc_inc   = outs_q.pc_inc;
    assign bus.pc_load  = outs_q.pc_load;
    assign bus.ins_load = outs_q.ins_load;
    assign bus.ext_load = outs_q.ext_load;
    assign bus.ram_rd   = outs_q.ram_rd;
    assign bus.op1_load = outs_q.op1_load;
    assign bus.op2_load = outs_q.op2_load;
    assign bus.alu_ot   = outs_q.alu_ot;
    assign bus.reg_load = outs_q.reg_load;
    assign bus.busy     = outs_q.busy;
    assign bus.halted   = outs_q.halted;
    assign bus.illegal  = outs_q.illegal;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer: one unit with unit latencies, one with
// ROM_LAT=3 / RAM_LAT=2, checked cycle by cycle against hand-derived output vectors.
module tb_cpu_step_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_step_sequencer_if #(.CNT_W(16)) a_if ();
    cpu_step_sequencer_if #(.CNT_W(16)) b_if ();

    cpu_step_sequencer #(.ROM_LAT(1), .RAM_LAT(1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    cpu_step_sequencer #(.ROM_LAT(3), .RAM_LAT(2), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    // Output vector: {pc_inc,pc_load,ins_load,ext_load,ram_rd,op1_load,op2_load,alu_ot,reg_load,busy,halted,illegal}
    localparam logic [12:0] NONE  = 13'h0000;
    localparam logic [12:0] PCI   = 13'h1000;
    localparam logic [12:0] INS   = 13'h0400;
    localparam logic [12:0] EXT   = 13'h0200;
    localparam logic [12:0] RAM   = 13'h0100;
    localparam logic [12:0] OPS   = 13'h00C0;
    localparam logic [12:0] ALU01 = 13'h0010;
    localparam logic [12:0] REG   = 13'h0008;
    localparam logic [12:0] BUSY  = 13'h0004;
    localparam logic [12:0] HALT  = 13'h0002;
    localparam logic [12:0] ILL   = 13'h0001;

    logic [12:0] exp_b [1:12];

    function automatic logic [12:0] obs_a();
        return {a_if.pc_inc, a_if.pc_load, a_if.ins_load, a_if.ext_load, a_if.ram_rd,
                a_if.op1_load, a_if.op2_load, a_if.alu_ot, a_if.reg_load, a_if.busy,
                a_if.halted, a_if.illegal};
    endfunction

    function automatic logic [12:0] obs_b();
        return {b_if.pc_inc, b_if.pc_load, b_if.ins_load, b_if.ext_load, b_if.ram_rd,
                b_if.op1_load, b_if.op2_load, b_if.alu_ot, b_if.reg_load, b_if.busy,
                b_if.halted, b_if.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_b[1]  = BUSY;
        exp_b[2]  = BUSY;
        exp_b[3]  = PCI | INS | BUSY;
        exp_b[4]  = BUSY;
        exp_b[5]  = BUSY;
        exp_b[6]  = BUSY;
        exp_b[7]  = PCI | EXT | BUSY;
        exp_b[8]  = RAM | BUSY;
        exp_b[9]  = RAM | BUSY;
        exp_b[10] = OPS | BUSY;
        exp_b[11] = ALU01 | BUSY;
        exp_b[12] = REG | BUSY;

        rst = 1'b1;
        a_if.en = 1'b0; a_if.ins_word = '0;
        b_if.en = 1'b0; b_if.ins_word = '0;
        step(); step();
        check("reset_outs", obs_a(), NONE);
        check("reset_retired", a_if.retired, 0);

        // 1-word register op 0x4283
        rst = 1'b0; a_if.en = 1'b1; a_if.ins_word = 16'h4283;
        step(); check("reg_fetch", obs_a(), PCI | INS | BUSY);
        step(); check("reg_decode", obs_a(), BUSY);
        step(); check("reg_oprd", obs_a(), OPS | BUSY);
        step(); check("reg_exec", obs_a(), BUSY);
        a_if.ins_word = 16'hA480;
        step(); check("reg_wb", obs_a(), REG | BUSY);
        check("reg_ret_in_wb", a_if.retired, 0);

        // 2-word direct op 0xA480 follows back to back
        step(); check("dir_fetch", obs_a(), PCI | INS | BUSY);
        check("dir_ret_after_reg", a_if.retired, 1);
        step(); check("dir_decode", obs_a(), BUSY);
        step(); check("dir_fetch2", obs_a(), PCI | EXT | BUSY);
        step(); check("dir_memrd", obs_a(), RAM | BUSY);
        step(); check("dir_oprd", obs_a(), OPS | BUSY);
        step(); check("dir_exec", obs_a(), ALU01 | BUSY);
        a_if.ins_word = 16'h4283;
        step(); check("dir_wb", obs_a(), REG | BUSY);

        // en dropped during OPRD: instruction still completes, then IDLE
        step(); check("drop_fetch", obs_a(), PCI | INS | BUSY);
        check("drop_ret_after_dir", a_if.retired, 2);
        step(); check("drop_decode", obs_a(), BUSY);
        step(); check("drop_oprd", obs_a(), OPS | BUSY);
        a_if.en = 1'b0;
        step(); check("drop_exec", obs_a(), BUSY);
        step(); check("drop_wb", obs_a(), REG | BUSY);
        step(); check("drop_idle", obs_a(), NONE);
        check("drop_retired", a_if.retired, 3);
        step(); check("drop_idle_hold", obs_a(), NONE);

        // Reassert en with HALT 0x400F
        a_if.en = 1'b1; a_if.ins_word = 16'h400F;
        step(); check("halt_fetch", obs_a(), PCI | INS | BUSY);
        step(); check("halt_decode", obs_a(), BUSY);
        step(); check("halt_state", obs_a(), HALT);
        for (int i = 0; i < 6; i++) begin
            a_if.en = i[0];
            step();
            check("halt_sticky", obs_a(), HALT);
            check("halt_retired", a_if.retired, 3);
        end
        rst = 1'b1;
        step(); check("halt_rst_outs", obs_a(), NONE);
        check("halt_rst_retired", a_if.retired, 0);

        // Illegal OT=11 traps
        rst = 1'b0; a_if.en = 1'b1; a_if.ins_word = 16'h4C00;
        step(); check("trap_fetch", obs_a(), PCI | INS | BUSY);
        step(); check("trap_decode", obs_a(), BUSY);
        for (int i = 0; i < 20; i++) begin
            step();
            check("trap_sticky", obs_a(), ILL);
            check("trap_retired", a_if.retired, 0);
        end
        rst = 1'b1;
        step(); check("trap_rst", obs_a(), NONE);
        rst = 1'b0; a_if.en = 1'b0;
        step(); check("trap_rst_idle", obs_a(), NONE);

        // ROM_LAT=3, RAM_LAT=2 direct op: first FETCH at cycle 1, WB at cycle 12
        b_if.en = 1'b1; b_if.ins_word = 16'hA480;
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("lat_cycle%0d", c), obs_b(), exp_b[c]);
        end
        step(); check("lat_next_fetch", obs_b(), BUSY);
        check("lat_retired", b_if.retired, 1);
        // Second instance of the same instruction, reset during its first MEMRD cycle
        for (int c = 14; c <= 20; c++) step();
        check("lat_memrd_again", obs_b(), RAM | BUSY);
        rst = 1'b1;
        step(); check("lat_rst_memrd", obs_b(), NONE);
        check("lat_rst_retired", b_if.retired, 0);
        rst = 1'b0; b_if.en = 1'b0;
        step(); check("lat_rst_idle", obs_b(), NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
